// File: rtl/score_hud_bcd.sv
// score_hud_bcd: binary score -> BCD digits and leading-zero blank masks for the HUD.
// A 2-flop synchroniser brings the 60 Hz score into the display domain. A sequential
// double-dabble converter handles one bit per clock. A session high score is kept.
// Ports:
//   clk, rst     display clock, synchronous active-high reset
//   score_in     binary score from the game controller (quasi-static)
//   clear_hi     pulse: zero the high score
//   score_bcd    current score BCD, digit 0 (units) in [3:0]
//   hi_bcd       high score BCD, same packing
//   score_blank  1 = suppress digit i of score (leading zero); digit 0 never blanked
//   hi_blank     1 = suppress digit i of high score
//   busy         conversion in progress
//   update       one-cycle pulse when new values are committed
module score_hud_bcd #(
  parameter int unsigned SCORE_W = 18,
  parameter int unsigned DIGITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    score_in,
  input  logic                  clear_hi,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hi_bcd,
  output logic [DIGITS-1:0]     score_blank,
  output logic [DIGITS-1:0]     hi_blank,
  output logic                  busy,
  output logic                  update
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state, state_nx;
  logic                load, commit;
  logic [SCORE_W-1:0]  s1, s2, last_bin, hi_bin, sh_bin;
  logic [BCD_W-1:0]    acc, acc_adj;
  logic [CNT_W-1:0]    cnt;

  // Digit i (i>=1) is blanked when it and every digit above it are zero.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] v);
    logic [DIGITS-1:0] b;
    logic              zero_above;
    b          = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (v[4*i +: 4] == 4'd0);
      b[i]       = zero_above;
    end
    return b;
  endfunction

  // Add-3 correction on every nibble ahead of the shift.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        // Only start on a stable, changed value.
        if ((s1 == s2) && (s2 != last_bin)) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) state_nx = COMMIT;
      end
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  // Synchroniser, converter datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      last_bin    <= '0;
      hi_bin      <= '0;
      sh_bin      <= '0;
      acc         <= '0;
      cnt         <= '0;
      score_bcd   <= '0;
      hi_bcd      <= '0;
      score_blank <= BLANK_RST;
      hi_blank    <= BLANK_RST;
      update      <= 1'b0;
    end else begin
      s1     <= score_in;
      s2     <= s1;
      update <= commit;

      if (load) begin
        sh_bin   <= s2;
        last_bin <= s2;
        acc      <= '0;
        cnt      <= CNT_W'(SCORE_W - 1);
      end else if (state == SHIFT) begin
        acc    <= BCD_W'({acc_adj, sh_bin[SCORE_W-1]});
        sh_bin <= {sh_bin[SCORE_W-2:0], 1'b0};
        cnt    <= cnt - CNT_W'(1);
      end

      if (commit) begin
        score_bcd   <= acc;
        score_blank <= blank_of(acc);
      end

      // Clear takes priority over folding a coincident commit into the high score.
      if (clear_hi) begin
        hi_bin   <= '0;
        hi_bcd   <= '0;
        hi_blank <= BLANK_RST;
      end else if (commit && (last_bin > hi_bin)) begin
        hi_bin   <= last_bin;
        hi_bcd   <= acc;
        hi_blank <= blank_of(acc);
      end
    end
  end

endmodule

// File: tb/tb_score_hud_bcd.sv
// Directed bench for score_hud_bcd: latency, conversion values, blanking,
// high-score tracking, clear_hi priority, input instability and mid-job reset.
module tb_score_hud_bcd;

  logic        clk;
  logic        rst;
  logic [17:0] score_in;
  logic        clear_hi;
  logic [23:0] score_bcd;
  logic [23:0] hi_bcd;
  logic [5:0]  score_blank;
  logic [5:0]  hi_blank;
  logic        busy;
  logic        update;

  int checks;
  int errors;

  score_hud_bcd #(.SCORE_W(18), .DIGITS(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .score_in    (score_in),
    .clear_hi    (clear_hi),
    .score_bcd   (score_bcd),
    .hi_bcd      (hi_bcd),
    .score_blank (score_blank),
    .hi_blank    (hi_blank),
    .busy        (busy),
    .update      (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until update is seen (bounded); n = edges taken.
  task automatic wait_update(input string tag, input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc) begin
      step();
      n++;
      if (update) break;
    end
    chk({tag, "_upd"}, 32'(update), 32'd1);
  endtask

  int n;
  logic seen;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    score_in = '0;
    clear_hi = 1'b0;
    step();
    step();
    chk("rst_score", 32'(score_bcd), 32'h0);
    chk("rst_hi", 32'(hi_bcd), 32'h0);
    chk("rst_sblank", 32'(score_blank), 32'h3E);
    chk("rst_hblank", 32'(hi_blank), 32'h3E);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_busy", 32'(busy), 32'd0);

    // 1234: latency 22 edges, single-cycle update.
    score_in = 18'd1234;
    wait_update("c1234", 40, n);
    chk("lat", 32'(n), 32'd22);
    chk("s1234", 32'(score_bcd), 32'h001234);
    chk("b1234", 32'(score_blank), 32'h30);
    chk("h1234", 32'(hi_bcd), 32'h001234);
    chk("hb1234", 32'(hi_blank), 32'h30);
    step();
    chk("upd_1cyc", 32'(update), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);

    // Max value, then a lower score keeps the high score.
    score_in = 18'd262143;
    wait_update("cmax", 40, n);
    chk("smax", 32'(score_bcd), 32'h262143);
    chk("bmax", 32'(score_blank), 32'h00);
    chk("hmax", 32'(hi_bcd), 32'h262143);
    score_in = 18'd500;
    wait_update("c500", 40, n);
    chk("s500", 32'(score_bcd), 32'h000500);
    chk("b500", 32'(score_blank), 32'h38);
    chk("h500", 32'(hi_bcd), 32'h262143);
    chk("hb500", 32'(hi_blank), 32'h00);

    // Input change mid-conversion is picked up by a follow-on job.
    score_in = 18'd1234;
    repeat (12) step();
    chk("mid_busy", 32'(busy), 32'd1);
    score_in = 18'd1240;
    wait_update("cfirst", 40, n);
    chk("first_lat", 32'(n), 32'd10);
    chk("first_val", 32'(score_bcd), 32'h001234);
    step();
    wait_update("csecond", 40, n);
    chk("second_val", 32'(score_bcd), 32'h001240);
    chk("second_hi", 32'(hi_bcd), 32'h262143);

    // Unstable input never starts a job.
    for (int i = 0; i < 20; i++) begin
      score_in = (i % 2 == 0) ? 18'd100 : 18'd200;
      step();
      chk("toggle_busy", 32'(busy), 32'd0);
    end
    score_in = 18'd77;
    wait_update("c77", 40, n);
    chk("s77", 32'(score_bcd), 32'h000077);
    chk("b77", 32'(score_blank), 32'h3C);

    // clear_hi alone, then set hi to 300.
    clear_hi = 1'b1;
    step();
    clear_hi = 1'b0;
    chk("clr_hi", 32'(hi_bcd), 32'h0);
    chk("clr_hblank", 32'(hi_blank), 32'h3E);
    score_in = 18'd300;
    wait_update("c300", 40, n);
    chk("h300", 32'(hi_bcd), 32'h000300);

    // clear_hi on the COMMIT cycle of 900: clear wins, score still updates.
    score_in = 18'd900;
    repeat (21) step();
    chk("commit_busy", 32'(busy), 32'd1);
    clear_hi = 1'b1;
    step();
    clear_hi = 1'b0;
    chk("c900_upd", 32'(update), 32'd1);
    chk("s900", 32'(score_bcd), 32'h000900);
    chk("h900", 32'(hi_bcd), 32'h0);
    chk("hb900", 32'(hi_blank), 32'h3E);
    // High score really was zeroed: 600 now becomes the high score.
    score_in = 18'd600;
    wait_update("c600", 40, n);
    chk("h600", 32'(hi_bcd), 32'h000600);

    // Reset mid-SHIFT aborts and restores reset values.
    score_in = 18'd4321;
    repeat (10) step();
    rst      = 1'b1;
    score_in = 18'd0;
    step();
    rst = 1'b0;
    chk("ar_score", 32'(score_bcd), 32'h0);
    chk("ar_hi", 32'(hi_bcd), 32'h0);
    chk("ar_sblank", 32'(score_blank), 32'h3E);
    chk("ar_hblank", 32'(hi_blank), 32'h3E);
    chk("ar_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (update || busy) seen = 1'b1;
    end
    chk("ar_quiet", 32'(seen), 32'd0);
    chk("ar_score2", 32'(score_bcd), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
